regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised successor to the single-write, two-read CPU register file.
- Adds configurable width, depth and read-port count, byte-enable writes, optional hard-wired zero register, and optional write-to-read bypass.
- Array initialisation is done by a sequential init walker instead of an async reset of the whole array.
- Adds a registered debug read port; sits in the decode stage of the single-cycle core.

Parameters:
- XLEN, 32: register width in bits; must be a multiple of 8.
- NREGS, 32: number of registers; power of two, minimum 2.
- NRD, 2: number of read ports, 1..4.
- ZERO_REG, 1: 1 makes register 0 read as 0 and ignore writes.
- BYPASS, 1: 1 forwards a same-cycle write to matching read ports.
- INIT_MODE, 1: 0 initialises every register to 0; 1 initialises register i to value i.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- busy  out  1  high while the init walker runs.
- we  in  1  write enable.
- wa  in  AW  write address, AW=$clog2(NREGS).
- wd  in  XLEN  write data.
- wbe  in  XLEN/8  byte write enables.
- ra  in  NRD*AW  read addresses, port k at [k*AW +: AW].
- rd  out  NRD*XLEN  read data, port k at [k*XLEN +: XLEN], combinational.
- dbg_addr  in  AW  debug read address.
- dbg_data  out  XLEN  debug read data, registered.
- wr_drop  out  1  pulse: a write was discarded because it arrived during init.

Behaviour:
- Reset asserted (reset=0), asynchronously:
  - FSM goes to INIT, init_ptr=0, busy=1, dbg_data=0, wr_drop=0.
  - Array contents are not reset; they are undefined until rewritten by the walker.
- FSM states:
  - INIT: each posedge writes the init value (0, or init_ptr per INIT_MODE) to reg[init_ptr], then init_ptr++.
  - Leave INIT on the posedge that writes reg[NREGS-1]; move to READY and drop busy.
  - busy is high for exactly NREGS posedges after reset deasserts.
  - READY: stays until the next reset assertion.
- Reset asserted mid-INIT or in READY: restarts the walk from 0 and discards any in-flight write.
- Writes in READY:
  - On posedge, when we=1, byte b of reg[wa] takes wd byte b for each b with wbe[b]=1; other bytes hold.
  - wbe=0 is a no-op.
  - If ZERO_REG=1 and wa=0, the write is ignored.
- Writes during INIT:
  - Ignored.
  - wr_drop=1 for the cycle after any posedge that sampled we=1 with busy=1; otherwise wr_drop=0.
- Reads:
  - During INIT, every rd port outputs 0.
  - In READY, rd[k] = reg[ra[k]].
  - If ZERO_REG=1 and ra[k]=0, rd[k]=0 regardless of bypass.
- Bypass (BYPASS=1, READY, we=1, wa==ra[k], write not ignored):
  - rd[k] byte b = wd byte b where wbe[b]=1, else the stored byte.
  - The result is visible combinationally in the same cycle.
  - BYPASS=0: rd[k] shows the new value only after the posedge.
- Multiple read ports with the same address return identical data.
- dbg_data:
  - Updated on every posedge with the stored reg[dbg_addr], without bypass; one-cycle latency.
  - Loads 0 while busy=1 and on the posedge that ends INIT.
- Address width: addresses are exactly AW bits, so every address is in range and there is no out-of-bounds case.

Test Plan:
- Release reset, INIT_MODE=1, NREGS=32:
  - busy is high for 32 posedges, then 0.
  - ra[0]=5 gives rd=0 during init and 32'd5 after.
  - dbg_addr=31 gives dbg_data=31 one cycle after busy falls.
- we=1 with wa=3 on the 2nd post-reset posedge -> wr_drop=1 the next cycle; reg3 still reads 3 after init.
- Byte writes in READY:
  - reg7=7, then wa=7, wd=32'hAABBCCDD, wbe=4'b0101 -> reg7 = 32'h00BB00DD after the edge.
  - With BYPASS=1 and ra[1]=7 in the same cycle, rd[1] = 32'h00BB00DD before the edge.
- ZERO_REG=1: write wa=0, wd=32'hFFFFFFFF, wbe=4'hF -> rd with ra=0 stays 0 both before and after the edge, with no bypass.
- BYPASS=0: wa=ra[0]=9, wd=32'h12345678, wbe=4'hF -> rd[0]=9 before the edge and 32'h12345678 after.
- Assert reset while init_ptr=10 and reg2 has been written with 32'h55 -> busy restarts and runs a full 32-posedge walk; reg2 reads 2 afterwards.

Source files
------------

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: bus bundle for regfile_mp (write, read, debug and status signals)
// master drives we/wa/wd/wbe/ra/dbg_addr; slave returns rd/dbg_data/busy/wr_drop.
interface regfile_mp_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(NREGS);
  logic                this_is_unused_guard;
  logic                we;
  logic [AW-1:0]       wa;
  logic [XLEN-1:0]     wd;
  logic [XLEN/8-1:0]   wbe;
  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rd;
  logic [AW-1:0]       dbg_addr;
  logic [XLEN-1:0]     dbg_data;
  logic                busy;
  logic                wr_drop;
  modport master (output we, wa, wd, wbe, ra, dbg_addr, input rd, dbg_data, busy, wr_drop);
  modport slave  (input we, wa, wd, wbe, ra, dbg_addr, output rd, dbg_data, busy, wr_drop);
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read-port register file with init walker, byte writes and bypass
// clk: clock; reset: async active-low, restarts the init walk
// bus.we/wa/wd/wbe: byte-enabled write; bus.ra/rd: NRD combinational read ports
// bus.dbg_addr/dbg_data: registered debug read; bus.busy: init in progress; bus.wr_drop: write lost to init
module regfile_mp #(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter int NRD       = 2,
  parameter int ZERO_REG  = 1,
  parameter int BYPASS    = 1,
  parameter int INIT_MODE = 1
) (
  input logic         clk,
  input logic         reset,
  regfile_mp_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  localparam int NB = XLEN / 8;
  typedef enum logic {INIT, READY} state_t;
  state_t              state, state_n;
  logic [AW-1:0]       init_ptr, ptr_n;
  logic [XLEN-1:0]     mem [NREGS];
  logic                busy, wr_ok, drop_q;
  logic [XLEN-1:0]     dbg_q;
  logic [NRD*XLEN-1:0] rd_c;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state    <= INIT;
      init_ptr <= '0;
    end else begin
      state    <= state_n;
      init_ptr <= ptr_n;
    end
  always_comb begin
    state_n = state;
    ptr_n   = init_ptr;
    if (state == INIT) begin
      ptr_n   = init_ptr + 1'b1;
      state_n = (init_ptr == AW'(NREGS - 1)) ? READY : INIT;
    end
  end
  assign busy  = state == INIT;
  assign wr_ok = !busy && bus.we && !(ZERO_REG != 0 && bus.wa == '0);
  // The array has no reset; while reset is held the walker just keeps rewriting reg 0 with its init value.
  always_ff @(posedge clk)
    if (busy) mem[init_ptr] <= (INIT_MODE != 0) ? XLEN'(init_ptr) : '0;
    else if (wr_ok)
      for (int b = 0; b < NB; b++)
        if (bus.wbe[b]) mem[bus.wa][8*b +: 8] <= bus.wd[8*b +: 8];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      dbg_q  <= '0;
      drop_q <= 1'b0;
    end else begin
      dbg_q  <= busy ? '0 : mem[bus.dbg_addr];
      drop_q <= busy && bus.we;
    end
  always_comb begin
    rd_c = '0;
    for (int k = 0; k < NRD; k++) begin
      for (int b = 0; b < NB; b++)
        rd_c[k*XLEN + 8*b +: 8] = (BYPASS != 0 && wr_ok && bus.wa == bus.ra[k*AW +: AW] && bus.wbe[b])
                                  ? bus.wd[8*b +: 8] : mem[bus.ra[k*AW +: AW]][8*b +: 8];
      if (busy || (ZERO_REG != 0 && bus.ra[k*AW +: AW] == '0)) rd_c[k*XLEN +: XLEN] = '0;
    end
  end
  assign bus.rd       = rd_c;
  assign bus.dbg_data = dbg_q;
  assign bus.busy     = busy;
  assign bus.wr_drop  = drop_q;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: self-checking bench for regfile_mp, bypass (a) and no-bypass (b) instances side by side
module tb_regfile_mp;
  logic clk = 1'b0;
  logic reset;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2)) a ();
  regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2)) b ();
  assign b.we       = a.we;
  assign b.wa       = a.wa;
  assign b.wd       = a.wd;
  assign b.wbe      = a.wbe;
  assign b.ra       = a.ra;
  assign b.dbg_addr = a.dbg_addr;
  assign a.this_is_unused_guard = 1'b0;
  assign b.this_is_unused_guard = 1'b0;
  regfile_mp #(.BYPASS(1)) dut_a (.clk(clk), .reset(reset), .bus(a.slave));
  regfile_mp #(.BYPASS(0)) dut_b (.clk(clk), .reset(reset), .bus(b.slave));
  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [3:0]  wbe;
    logic [4:0]  ra0, ra1;
    logic [31:0] pa0, pa1;
    logic [31:0] pb0, pb1;
    logic [31:0] q0, q1;
  } vec_t;
  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] exp;
  } dbg_t;
  vec_t vec [8];
  dbg_t dv [7];
  logic [31:0] sb [$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic walk(output int n);
    n = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end while (a.busy && n < 100);
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    logic [31:0] e;
    vec[0] = '{1, 7, 32'hAABBCCDD, 4'b0101, 7, 7, 32'h00BB00DD, 32'h00BB00DD, 32'd7, 32'd7, 32'h00BB00DD, 32'h00BB00DD};
    vec[1] = '{1, 0, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0};
    vec[2] = '{1, 9, 32'h12345678, 4'hF, 9, 8, 32'h12345678, 32'd8, 32'd9, 32'd8, 32'h12345678, 32'd8};
    vec[3] = '{0, 10, 32'hDEADBEEF, 4'hF, 10, 10, 32'd10, 32'd10, 32'd10, 32'd10, 32'd10, 32'd10};
    vec[4] = '{1, 10, 32'hDEADBEEF, 4'h0, 10, 10, 32'd10, 32'd10, 32'd10, 32'd10, 32'd10, 32'd10};
    vec[5] = '{1, 31, 32'h11223344, 4'b1000, 31, 7, 32'h1100001F, 32'h00BB00DD, 32'h1F, 32'h00BB00DD, 32'h1100001F, 32'h00BB00DD};
    vec[6] = '{1, 7, 32'hCAFEF00D, 4'b0010, 6, 7, 32'd6, 32'h00BBF0DD, 32'd6, 32'h00BB00DD, 32'd6, 32'h00BBF0DD};
    vec[7] = '{1, 2, 32'h55, 4'hF, 2, 2, 32'h55, 32'h55, 32'd2, 32'd2, 32'h55, 32'h55};
    dv[0] = '{0, 7, 32'h00BBF0DD};
    dv[1] = '{0, 9, 32'h12345678};
    dv[2] = '{0, 31, 32'h1100001F};
    dv[3] = '{0, 0, 32'h0};
    dv[4] = '{1, 4, 32'd4};
    dv[5] = '{0, 4, 32'hFFFFFFFF};
    dv[6] = '{0, 2, 32'h55};
    reset = 1'b0;
    a.we = 0; a.wa = 0; a.wd = 0; a.wbe = 0; a.ra = 0; a.dbg_addr = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy_a", 32'(a.busy), 1);
    chk("rst_busy_b", 32'(b.busy), 1);
    chk("rst_dbg", a.dbg_data, 0);
    chk("rst_drop", 32'(a.wr_drop), 0);
    a.ra = {5'd5, 5'd5};
    a.dbg_addr = 5'd31;
    reset = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (n == 1) begin
        a.we = 1; a.wa = 3; a.wd = 32'hFFFFFFFF; a.wbe = 4'hF;
      end
      if (n == 2) begin
        chk("init_drop", 32'(a.wr_drop), 1);
        a.we = 0;
      end
      if (n == 3) chk("init_drop_clear", 32'(a.wr_drop), 0);
      if (n == 5) chk("init_rd0_zero", a.rd[31:0], 0);
      if (n == 6) chk("init_dbg_zero", a.dbg_data, 0);
    end while (a.busy && n < 100);
    chk("busy_len", n, 32);
    chk("busy_b_low", 32'(b.busy), 0);
    chk("ready_rd0", a.rd[31:0], 5);
    chk("ready_rd1", a.rd[63:32], 5);
    chk("dbg_end_init", a.dbg_data, 0);
    @(posedge clk);
    @(negedge clk);
    chk("dbg_31", a.dbg_data, 31);
    a.ra = {5'd0, 5'd3};
    #1;
    chk("dropped_reg3", a.rd[31:0], 3);
    chk("zero_reg_rd1", a.rd[63:32], 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a.we = vec[i].we; a.wa = vec[i].wa; a.wd = vec[i].wd; a.wbe = vec[i].wbe;
      a.ra = {vec[i].ra1, vec[i].ra0};
      #1;
      chk($sformatf("v%0d_a_rd0_pre", i), a.rd[31:0], vec[i].pa0);
      chk($sformatf("v%0d_a_rd1_pre", i), a.rd[63:32], vec[i].pa1);
      chk($sformatf("v%0d_b_rd0_pre", i), b.rd[31:0], vec[i].pb0);
      chk($sformatf("v%0d_b_rd1_pre", i), b.rd[63:32], vec[i].pb1);
      @(posedge clk);
      @(negedge clk);
      a.we = 0;
      #1;
      chk($sformatf("v%0d_a_rd0_post", i), a.rd[31:0], vec[i].q0);
      chk($sformatf("v%0d_a_rd1_post", i), a.rd[63:32], vec[i].q1);
      chk($sformatf("v%0d_b_rd0_post", i), b.rd[31:0], vec[i].q0);
      chk($sformatf("v%0d_b_rd1_post", i), b.rd[63:32], vec[i].q1);
    end
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      a.dbg_addr = dv[i].addr;
      a.we = dv[i].we; a.wa = dv[i].addr; a.wd = 32'hFFFFFFFF; a.wbe = 4'hF;
      sb.push_back(dv[i].exp);
      @(posedge clk);
      #1;
      a.we = 0;
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("dbg%0d_a", i), a.dbg_data, e);
      chk($sformatf("dbg%0d_b", i), b.dbg_data, e);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rerst_busy", 32'(a.busy), 1);
    chk("rerst_dbg", a.dbg_data, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("mid_init_busy", 32'(a.busy), 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(a.busy), 1);
    @(negedge clk);
    reset = 1'b1;
    a.ra = {5'd7, 5'd2};
    walk(n);
    chk("rewalk_len", n, 32);
    chk("rewalk_reg2", a.rd[31:0], 2);
    chk("rewalk_reg7", a.rd[63:32], 7);
    chk("rewalk_b_reg2", b.rd[31:0], 2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
